// File: rtl/sdram_line_prefetch.sv
// Optional sticky Underrun flag is built only when SDRAM_PREFETCH_UNDERRUN_EN is defined.

// prefetch_fifo: show-ahead word FIFO. The head is read combinationally.
// Latency: a pushed word is on head_dat the cycle after the push.
// Backpressure: a push into a full FIFO is dropped unless it pairs with a pop. A pop while empty is ignored.
module prefetch_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 32
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok   = pop && (count != '0);
    assign push_ok  = push && ((count != CW'(DEPTH)) || pop_ok);
    assign head_dat = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge Clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// sdram_line_prefetch: reads LINE_WORDS consecutive words from Base into a local FIFO for a streaming consumer.
// Latency: each word appears on Q/Valid one cycle after its sd_R.
// Backpressure: when the FIFO is full, the fetcher stalls with sd_Focus low. It resumes once RESUME_LVL slots are free.
module sdram_line_prefetch #(
    parameter int DEPTH      = 32,
    parameter int LINE_WORDS = 640,
    parameter int RESUME_LVL = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [24:0] Base,
    output logic        Busy,
    output logic        Done,
    input  logic        Pop,
    output logic [15:0] Q,
    output logic        Valid,
    output logic [24:0] sd_Addr,
    output logic [15:0] sd_Din,
    output logic        sd_WE,
    output logic        sd_Focus,
    input  logic        sd_R,
`ifdef SDRAM_PREFETCH_UNDERRUN_EN
    input  logic        UnderrunClr,
    output logic        Underrun,
`endif
    input  logic [15:0] sd_Dout
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

    state_t        state;
    logic [24:0]   base_q;
    logic [15:0]   idx;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full;
    logic          pop_ok;
    logic          take;
    logic          last;

    assign sd_Din     = '0;
    assign sd_WE      = 1'b0;
    assign Valid      = (count != '0);
    assign full       = (count == CW'(DEPTH));
    assign pop_ok     = Pop && Valid;
    // A full FIFO in FETCH only arises when a line starts on top of unread data; hold off instead of overrunning.
    assign take       = (state == FETCH) && sd_R && (!full || pop_ok);
    assign last       = (idx == 16'(LINE_WORDS - 1));
    assign count_next = count + CW'(take) - CW'(pop_ok);

    prefetch_fifo #(.W(16), .DEPTH(DEPTH)) u_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     (take),
        .push_dat (sd_Dout),
        .pop      (Pop),
        .head_dat (Q),
        .count    (count)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            base_q   <= '0;
            idx      <= '0;
            sd_Addr  <= '0;
            sd_Focus <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state    <= FETCH;
                        base_q   <= Base;
                        idx      <= '0;
                        sd_Addr  <= Base;
                        sd_Focus <= 1'b1;
                        Busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (take) begin
                        idx     <= idx + 16'd1;
                        sd_Addr <= base_q + 25'(idx) + 25'd1;
                        if (last) begin
                            state    <= IDLE;
                            Done     <= 1'b1;
                            Busy     <= 1'b0;
                            sd_Focus <= 1'b0;
                        end else if (count_next == CW'(DEPTH)) begin
                            state    <= STALL;
                            sd_Focus <= 1'b0;
                        end
                    end else if (full && !pop_ok) begin
                        state    <= STALL;
                        sd_Focus <= 1'b0;
                    end
                end
                STALL: begin
                    if ((CW'(DEPTH) - count) >= CW'(RESUME_LVL)) begin
                        state    <= FETCH;
                        sd_Focus <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    sd_Focus <= 1'b0;
                    Busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef SDRAM_PREFETCH_UNDERRUN_EN
    always_ff @(posedge Clk) begin
        if (Reset)
            Underrun <= 1'b0;
        else if (Pop && !Valid && Busy)
            Underrun <= 1'b1;
        else if (UnderrunClr)
            Underrun <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_sdram_line_prefetch.sv
// Bench for sdram_line_prefetch: an SDRAM responder plus an in-order word scoreboard, using directed and random phases.
module tb_sdram_line_prefetch;
    localparam int DEPTH = 8;
    localparam int LINE  = 10;
    localparam int RLVL  = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [24:0] Base = '0;
    logic        Pop = 1'b0;
    logic        sd_R = 1'b0;
    logic [15:0] sd_Dout = '0;
    logic        Busy, Done, Valid, sd_WE, sd_Focus;
    logic [15:0] Q, sd_Din;
    logic [24:0] sd_Addr;
`ifdef SDRAM_PREFETCH_UNDERRUN_EN
    logic        UnderrunClr = 1'b0;
    logic        Underrun;
`endif

    sdram_line_prefetch #(.DEPTH(DEPTH), .LINE_WORDS(LINE), .RESUME_LVL(RLVL)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Base(Base), .Busy(Busy), .Done(Done),
        .Pop(Pop), .Q(Q), .Valid(Valid), .sd_Addr(sd_Addr), .sd_Din(sd_Din), .sd_WE(sd_WE),
        .sd_Focus(sd_Focus), .sd_R(sd_R),
`ifdef SDRAM_PREFETCH_UNDERRUN_EN
        .UnderrunClr(UnderrunClr), .Underrun(Underrun),
`endif
        .sd_Dout(sd_Dout));

    always #5 Clk = ~Clk;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q[$];
    logic [24:0] exp_base = '0;
    int          nacc = 0;
    bit          exp_busy = 0;
    int          n_done = 0;
    int          lines = 0;
    int          popped = 0;
    logic [24:0] addr_log [4];
    int          n_log = 0;

    function automatic logic [15:0] word_at(input logic [24:0] a);
        return a[15:0] ^ {7'h0, a[24:16]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive the responder and consumer, advance the scoreboard, then check after the edge.
    task automatic tick(input bit r, input bit p);
        logic [24:0] a_exp;
        bit push, pop_e, done_e;
        a_exp   = '0;
        sd_R    = r;
        Pop     = p;
        sd_Dout = r ? word_at(sd_Addr) : 16'($urandom);
        push    = r && (sd_Focus === 1'b1);
        pop_e   = p && (exp_q.size() != 0);
        done_e  = 0;
        if (push) begin
            a_exp = exp_base + 25'(nacc);
            chk("rd_addr", 32'(sd_Addr), 32'(a_exp));
            if (n_log < 4) begin
                addr_log[n_log] = sd_Addr;
                n_log++;
            end
            nacc++;
        end
        if (pop_e) begin
            void'(exp_q.pop_front());
            popped++;
        end
        if (push) exp_q.push_back(word_at(a_exp));
        if (push && nacc == LINE) begin
            done_e   = 1;
            exp_busy = 0;
        end
        @(posedge Clk); #1;
        sd_R = 1'b0;
        Pop  = 1'b0;
        chk("done", 32'(Done), 32'(done_e));
        chk("busy", 32'(Busy), 32'(exp_busy));
        chk("valid", 32'(Valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("q_head", 32'(Q), 32'(exp_q[0]));
        if (exp_q.size() == DEPTH || !exp_busy) chk("focus_off", 32'(sd_Focus), 32'd0);
        if (Done === 1'b1) n_done++;
    endtask

    task automatic start(input logic [24:0] b);
        Start = 1'b1;
        Base  = b;
        @(posedge Clk); #1;
        Start    = 1'b0;
        exp_base = b;
        nacc     = 0;
        exp_busy = 1;
        n_log    = 0;
        lines++;
        chk("start_busy", 32'(Busy), 32'd1);
        chk("start_focus", 32'(sd_Focus), 32'd1);
        chk("start_addr", 32'(sd_Addr), 32'(b));
    endtask

    // mode 0: read every 3rd cycle and random pops; mode 1: read and pop every cycle; mode 2: fully random.
    task automatic drain(input int mode, input int budget);
        int i;
        bit r, p;
        for (i = 0; i < budget && (exp_busy || exp_q.size() != 0); i++) begin
            case (mode)
                0:       begin r = (i % 3 == 2);          p = $urandom_range(0, 1) == 1; end
                1:       begin r = 1;                     p = 1;                         end
                default: begin r = $urandom_range(0, 2) != 0; p = $urandom_range(0, 3) != 0; end
            endcase
            tick(r, p);
        end
        chk("drain_in_budget", 32'(exp_busy || exp_q.size() != 0), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_addr", 32'(sd_Addr), 32'd0);
        chk("rst_focus", 32'(sd_Focus), 32'd0);
        chk("rst_we", 32'(sd_WE), 32'd0);
        chk("rst_din", 32'(sd_Din), 32'd0);
        Reset = 1'b0;
        tick(0, 0);

        // Fill without popping: the fetcher must park at a full FIFO with Focus low.
        start(25'h100);
        for (int i = 0; i < 30; i++) tick(i % 3 == 2, 0);
        chk("stall_focus", 32'(sd_Focus), 32'd0);
        chk("stall_addr", 32'(sd_Addr), 32'h108);
        chk("stall_full", 32'(exp_q.size()), 32'(DEPTH));

        // A read completion and a pop together while stalled: the word is dropped and the address is kept.
        tick(1, 1);
        chk("stall_pop_addr", 32'(sd_Addr), 32'h108);
        chk("stall_pop_cnt", 32'(exp_q.size()), 32'd7);
        chk("stall_pop_focus", 32'(sd_Focus), 32'd0);
        for (int i = 0; i < 3; i++) tick(0, 1);
        chk("still_stalled", 32'(sd_Focus), 32'd0);
        tick(0, 0);
        chk("resume_focus", 32'(sd_Focus), 32'd1);
        chk("resume_addr", 32'(sd_Addr), 32'h108);
        drain(0, 400);
        chk("line1_words", 32'(popped), 32'(LINE));

        // Address wrap at the top of the 25-bit space.
        start(25'h1FFFFFE);
        drain(1, 200);
        chk("wrap_a0", 32'(addr_log[0]), 32'h1FFFFFE);
        chk("wrap_a1", 32'(addr_log[1]), 32'h1FFFFFF);
        chk("wrap_a2", 32'(addr_log[2]), 32'h0000000);
        chk("wrap_a3", 32'(addr_log[3]), 32'h0000001);

        // Reset after three words: the FIFO is flushed, the FSM goes idle, and no Done pulse follows.
        start(25'h2000);
        for (int i = 0; i < 3; i++) tick(1, 0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("mid_rst_valid", 32'(Valid), 32'd0);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_focus", 32'(sd_Focus), 32'd0);
        chk("mid_rst_done", 32'(Done), 32'd0);
        exp_q.delete();
        exp_busy = 0;
        lines--;
        tick(1, 1);
        start(25'h3000);
        drain(2, 600);

        for (int l = 0; l < 4; l++) begin
            start(25'($urandom));
            drain(2, 800);
        end

`ifdef SDRAM_PREFETCH_UNDERRUN_EN
        tick(0, 1);
        chk("unr_idle", 32'(Underrun), 32'd0);
        start(25'h4000);
        tick(0, 1);
        chk("unr_set", 32'(Underrun), 32'd1);
        tick(0, 0);
        chk("unr_held", 32'(Underrun), 32'd1);
        UnderrunClr = 1'b1;
        tick(0, 0);
        UnderrunClr = 1'b0;
        chk("unr_clr", 32'(Underrun), 32'd0);
        drain(1, 200);
        tick(0, 1);
        chk("unr_idle2", 32'(Underrun), 32'd0);
`endif

        chk("done_pulses", 32'(n_done), 32'(lines));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
